output_uart_tx: RTL

- Sink for the processor's output port: captures each byte presented on the single-cycle output strobe and transmits it as an 8N1 UART frame on a serial line.
- The processor has no backpressure, so a small FIFO absorbs bursts from output loops.
- A sticky overflow flag records any bytes that had to be dropped.
- Sits at top level between the cpu output bus (data_out/data_out_en) and the board TX pin.

---
 rtl/bf_io_pkg.sv | 26 ++
 rtl/sync_fifo.sv | 80 ++++++++
 rtl/output_uart_tx.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/bf_io_pkg.sv
// ---------------------------------------------------------------------------
// bf_io_pkg
// Shared definitions for the processor I/O blocks: UART state encodings and
// default timing/FIFO sizing constants used by the output transmitter and the
// input receiver.
// ---------------------------------------------------------------------------
package bf_io_pkg;

    // UART serializer states
    typedef enum logic [1:0] {
        UART_IDLE  = 2'd0,
        UART_START = 2'd1,
        UART_DATA  = 2'd2,
        UART_STOP  = 2'd3
    } uart_state_e;

    localparam int unsigned DATA_WIDTH_DEFAULT      = 8;
    localparam int unsigned CLKS_PER_BIT_DEFAULT    = 868;   // 100 MHz / 115200
    localparam int unsigned FIFO_ADDR_WIDTH_DEFAULT = 4;

    // Counter width for a range of v values, never narrower than one bit
    function automatic int unsigned clog2_min1(input int unsigned v);
        return (v > 1) ? $clog2(v) : 1;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// ---------------------------------------------------------------------------
// sync_fifo
// Single-clock FIFO with registered read data and registered full/empty flags.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
//
// Ports:
//   clk        system clock
//   rst        asynchronous active-high reset (pointers and flags)
//   push_i     write wr_data_i this edge (caller guarantees room or a pop)
//   wr_data_i  data to write
//   pop_i      read the head into rd_data_o this edge (caller guarantees data)
//   rd_data_o  registered head value captured by the last pop
//   full_o     FIFO holds 2^ADDR_WIDTH entries
//   empty_o    FIFO holds no entries
// ---------------------------------------------------------------------------
module sync_fifo #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push_i,
    input  logic [DATA_WIDTH-1:0] wr_data_i,
    input  logic                  pop_i,
    output logic [DATA_WIDTH-1:0] rd_data_o,
    output logic                  full_o,
    output logic                  empty_o
);

    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
    localparam int unsigned PTR_W = ADDR_WIDTH + 1;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q;
    logic [PTR_W-1:0]      wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q;
    logic [PTR_W-1:0]      rd_ptr_d;
    logic [DATA_WIDTH-1:0] rd_data_q;
    logic                  full_q;
    logic                  empty_q;

    // Next pointers; wrap naturally through the extra MSB
    always_comb begin
        wr_ptr_d = wr_ptr_q + PTR_W'(push_i);
        rd_ptr_d = rd_ptr_q + PTR_W'(pop_i);
    end

    // Storage; a push coincident with a pop on a full FIFO overwrites the
    // slot being read, which is safe because the read samples the old value
    always_ff @(posedge clk) begin
        if (push_i) begin
            mem_q[wr_ptr_q[ADDR_WIDTH-1:0]] <= wr_data_i;
        end
    end

    // Pointers, flags and read register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            rd_data_q <= '0;
            full_q    <= 1'b0;
            empty_q   <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            full_q   <= (wr_ptr_d[ADDR_WIDTH] != rd_ptr_d[ADDR_WIDTH]) &&
                        (wr_ptr_d[ADDR_WIDTH-1:0] == rd_ptr_d[ADDR_WIDTH-1:0]);
            empty_q  <= (wr_ptr_d == rd_ptr_d);
            if (pop_i) begin
                rd_data_q <= mem_q[rd_ptr_q[ADDR_WIDTH-1:0]];
            end
        end
    end

    assign rd_data_o = rd_data_q;
    assign full_o    = full_q;
    assign empty_o   = empty_q;

endmodule

// File: rtl/output_uart_tx.sv
// ---------------------------------------------------------------------------
// output_uart_tx
// Sink for the processor output port. Each byte strobed on data_in_en is
// buffered in a FIFO and sent as an 8N1 UART frame. Bytes arriving while the
// FIFO is full (and no pop is happening) are dropped and flagged in a sticky
// overflow bit.
//
// Ports:
//   clk           system clock, rising edge
//   rst           asynchronous active-high reset
//   data_in       byte from cpu data_out
//   data_in_en    one-cycle strobe qualifying data_in
//   overflow_clr  synchronous clear of overflow (a same-edge drop wins)
//   tx            UART serial line, idle high
//   busy          frame in progress or FIFO non-empty
//   fifo_full     FIFO holds 2^FIFO_ADDR_WIDTH entries
//   overflow      sticky drop indicator
// ---------------------------------------------------------------------------
module output_uart_tx
    import bf_io_pkg::*;
#(
    parameter int unsigned DATA_WIDTH      = DATA_WIDTH_DEFAULT,
    parameter int unsigned FIFO_ADDR_WIDTH = FIFO_ADDR_WIDTH_DEFAULT,
    parameter int unsigned CLKS_PER_BIT    = CLKS_PER_BIT_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  data_in_en,
    input  logic                  overflow_clr,
    output logic                  tx,
    output logic                  busy,
    output logic                  fifo_full,
    output logic                  overflow
);

    localparam int unsigned BAUD_W = clog2_min1(CLKS_PER_BIT);
    localparam int unsigned BIT_W  = clog2_min1(DATA_WIDTH);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_WIDTH - 1);

    uart_state_e           state_q;
    logic [BAUD_W-1:0]     baud_q;
    logic [BIT_W-1:0]      bit_q;
    logic [DATA_WIDTH-1:0] shift_q;
    logic                  tx_q;
    logic                  busy_q;
    logic                  overflow_q;

    logic                  fifo_full_s;
    logic                  fifo_empty_s;
    logic [DATA_WIDTH-1:0] fifo_rd_data_s;

    logic                  baud_end_c;
    logic                  pop_c;
    logic                  push_c;
    logic                  drop_c;

    // Pop when idle with data waiting, or at the last stop-bit cycle so the
    // next frame starts without an idle gap. A pop frees a slot on the same
    // edge, so a full FIFO still accepts a byte then.
    always_comb begin
        baud_end_c = (baud_q == BAUD_LAST);
        pop_c      = ~fifo_empty_s &
                     ((state_q == UART_IDLE) |
                      ((state_q == UART_STOP) & baud_end_c));
        push_c     = data_in_en & (~fifo_full_s | pop_c);
        drop_c     = data_in_en & fifo_full_s & ~pop_c;
    end

    sync_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (FIFO_ADDR_WIDTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push_i    (push_c),
        .wr_data_i (data_in),
        .pop_i     (pop_c),
        .rd_data_o (fifo_rd_data_s),
        .full_o    (fifo_full_s),
        .empty_o   (fifo_empty_s)
    );

    // Serializer FSM. The line and busy registers follow the state one cycle
    // later, which gives the popped byte time to land in the FIFO read
    // register before it is loaded into the shift register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= UART_IDLE;
            baud_q     <= '0;
            bit_q      <= '0;
            shift_q    <= '0;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            busy_q <= (state_q != UART_IDLE) | ~fifo_empty_s;

            if (drop_c) begin
                overflow_q <= 1'b1;
            end else if (overflow_clr) begin
                overflow_q <= 1'b0;
            end

            case (state_q)
                UART_IDLE: begin
                    tx_q   <= 1'b1;
                    baud_q <= '0;
                    if (!fifo_empty_s) begin
                        state_q <= UART_START;
                    end
                end
                UART_START: begin
                    tx_q <= 1'b0;
                    if (baud_end_c) begin
                        baud_q  <= '0;
                        bit_q   <= '0;
                        shift_q <= fifo_rd_data_s;
                        state_q <= UART_DATA;
                    end else begin
                        baud_q <= baud_q + BAUD_W'(1);
                    end
                end
                UART_DATA: begin
                    tx_q <= shift_q[0];
                    if (baud_end_c) begin
                        baud_q  <= '0;
                        shift_q <= {1'b0, shift_q[DATA_WIDTH-1:1]};
                        if (bit_q == BIT_LAST) begin
                            state_q <= UART_STOP;
                        end else begin
                            bit_q <= bit_q + BIT_W'(1);
                        end
                    end else begin
                        baud_q <= baud_q + BAUD_W'(1);
                    end
                end
                UART_STOP: begin
                    tx_q <= 1'b1;
                    if (baud_end_c) begin
                        baud_q  <= '0;
                        state_q <= fifo_empty_s ? UART_IDLE : UART_START;
                    end else begin
                        baud_q <= baud_q + BAUD_W'(1);
                    end
                end
                default: begin
                    tx_q    <= 1'b1;
                    baud_q  <= '0;
                    state_q <= UART_IDLE;
                end
            endcase
        end
    end

    assign tx        = tx_q;
    assign busy      = busy_q;
    assign fifo_full = fifo_full_s;
    assign overflow  = overflow_q;

endmodule
